ts_tracklet_readout_sched: RTL
==============================

# ts_tracklet_readout_sched

Sequencer that drains the tracklet-count FIFO and schedules readout of the three module-pair tracklet memories (a, b, c). It sits between the count FIFO and the tracklet readout mux. For each event it pops one packed count word, then issues exactly cnt_a, cnt_b and cnt_c read strobes, in that order, to the matching pair. Pairs with a zero count are skipped, and it flags the last read of the event.

## Interface
- CNT_BITS, 6: width of one per-pair tracklet count.
- MAX_TRK, 48: per-event read cap (used only with TS_SCHED_TRUNC_EN).
- clk  in  1: fast processing clock.
- reset  in  1: asynchronous, active-low reset.
- cnt_fifo_dout  in  3*CNT_BITS: packed counts. A in [CNT_BITS-1:0], B in [2*CNT_BITS-1:CNT_BITS], C in [3*CNT_BITS-1:2*CNT_BITS]. Valid the cycle after cnt_fifo_rd_en.
- cnt_fifo_empty  in  1: count FIFO empty.
- out_ready  in  1: downstream can accept a tracklet this cycle.
- cnt_fifo_rd_en  out  1: pop strobe to the count FIFO.
- trk_rd_en  out  3: one-hot read strobe; bit0=a, bit1=b, bit2=c.
- trk_sel  out  2: pair index of the current read (0=a, 1=b, 2=c). Valid when any trk_rd_en bit is set.
- trk_last  out  1: high with the final trk_rd_en of the event.
- evt_done  out  1: one-cycle pulse at event completion.
- busy  out  1: high in every state except IDLE.
- trunc  out  1: event was truncated (TS_SCHED_TRUNC_EN only; otherwise tied 0).

## Operation
- The FSM has six states: IDLE, LOAD, RUN_A, RUN_B, RUN_C, DONE.
- **IDLE**
  - If cnt_fifo_empty=0: cnt_fifo_rd_en=1 for this cycle only, then go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - Latch the three counts into rem_a, rem_b and rem_c.
  - Go to the first of RUN_A, RUN_B, RUN_C whose latched count is nonzero.
  - If all three are zero, go to DONE.
- **RUN_x**
  - trk_rd_en[x] = out_ready (combinational); trk_sel = x.
  - On each cycle with out_ready=1, decrement rem_x.
  - When rem_x==1 and out_ready=1, advance to the next nonzero later pair, or to DONE if none remains.
  - With out_ready=0, hold state and counts; no strobe is issued.
- **trk_last** = trk_rd_en strobe issued AND no reads remain after it in the event.
- **DONE**: evt_done=1, then go to IDLE. cnt_fifo_rd_en is never asserted in DONE.
- Counts are unsigned. Total reads per event = cnt_a+cnt_b+cnt_c, at most 3*(2^CNT_BITS-1).
- No more than one trk_rd_en bit is ever high at a time.
- A count FIFO read is never issued while busy=1. Only one event is in flight.

## Timing
- Reset (reset=0, asynchronous) puts the FSM in IDLE, clears rem_* and forces all outputs to 0. Release is synchronous to clk.
- Reset mid-event abandons the event. The popped count word is lost; no evt_done is issued.
- Pop-to-first-strobe latency: cnt_fifo_rd_en in cycle N, LOAD in N+1, first possible trk_rd_en in N+2.
- With out_ready held high, an event with total T>0 reads occupies T+3 cycles from IDLE back to IDLE. An all-zero event occupies 3 cycles: IDLE, LOAD, DONE.
- Back-to-back events: the next cnt_fifo_rd_en occurs at the earliest in the cycle after DONE.
- cnt_fifo_empty is sampled only in IDLE. Its value in other states is ignored.

## Configuration
- **TS_SCHED_TRUNC_EN defined**
  - A per-event issued-read counter, cleared in LOAD, is compared against MAX_TRK.
  - When the counter reaches MAX_TRK, the strobe that reaches it carries trk_last=1. The FSM then goes to DONE, skipping the remaining reads.
  - trunc is set in DONE only if reads were skipped, and is held until the next LOAD or reset.
- **TS_SCHED_TRUNC_EN undefined**
  - No counter is built; all counted reads are issued.
  - trunc is constant 0 and MAX_TRK is unused.

## Test plan
- **Reset and idle**: reset=0 with cnt_fifo_empty=0 → all outputs 0. After release, cnt_fifo_rd_en=1 in the first cycle, then LOAD.
- **Basic event**: word a=2, b=0, c=1, out_ready=1 → trk_sel sequence 0,0,2 on consecutive cycles; trk_last on the third strobe; evt_done one cycle later; B never strobed.
- **All-zero word**: a=b=c=0 → no trk_rd_en; evt_done exactly 2 cycles after cnt_fifo_rd_en; busy high for 2 cycles.
- **Backpressure**: a=3; out_ready toggles 1,0,0,1,1 → exactly 3 strobes, only in cycles where out_ready=1; counts preserved during stalls.
- **Back-to-back events with mid-event reset**: two queued words a=1 and b=1 → second pop occurs the cycle after the first evt_done. A third event a=5 reset after 2 strobes → IDLE, no evt_done; the next word is processed normally.
- **Truncation (TS_SCHED_TRUNC_EN, MAX_TRK=4)**: a=3, b=3 → exactly 4 strobes (sel 0,0,0,1); trk_last on the 4th; trunc=1 after DONE. A second run with the macro undefined gives 6 strobes and trunc=0.

Source files
------------

// File: rtl/ts_tracklet_readout_sched.sv
// ts_tracklet_readout_sched: pops one packed count word per event and issues cnt_a, cnt_b, cnt_c reads.
// Optional per-event read cap enabled by defining TS_SCHED_TRUNC_EN.
`default_nettype none

module ts_tracklet_readout_sched #(
  parameter int unsigned CNT_BITS = 6,
  parameter int unsigned MAX_TRK  = 48
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [3*CNT_BITS-1:0] cnt_fifo_dout_i,
  input  logic                  cnt_fifo_empty_i,
  input  logic                  out_ready_i,
  output logic                  cnt_fifo_rd_en_o,
  output logic [2:0]            trk_rd_en_o,
  output logic [1:0]            trk_sel_o,
  output logic                  trk_last_o,
  output logic                  evt_done_o,
  output logic                  busy_o,
  output logic                  trunc_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN_A = 3'd2,
    S_RUN_B = 3'd3,
    S_RUN_C = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] rem_a_q, rem_a_d;
  logic [CNT_BITS-1:0] rem_b_q, rem_b_d;
  logic [CNT_BITS-1:0] rem_c_q, rem_c_d;

  logic [CNT_BITS-1:0] ld_a, ld_b, ld_c;
  logic [CNT_BITS-1:0] cur_rem;
  logic                later_nz;
  logic                in_run;
  logic                strobe;
  logic                more_after;
  logic                cap_hit;

  assign ld_a = cnt_fifo_dout_i[CNT_BITS-1:0];
  assign ld_b = cnt_fifo_dout_i[2*CNT_BITS-1:CNT_BITS];
  assign ld_c = cnt_fifo_dout_i[3*CNT_BITS-1:2*CNT_BITS];

  // Remaining count of the active pair and whether any later pair still has reads.
  always_comb begin
    cur_rem   = '0;
    later_nz  = 1'b0;
    in_run    = 1'b0;
    trk_sel_o = 2'd0;
    case (state_q)
      S_RUN_A: begin
        cur_rem  = rem_a_q;
        later_nz = (rem_b_q != '0) || (rem_c_q != '0);
        in_run   = 1'b1;
      end
      S_RUN_B: begin
        cur_rem   = rem_b_q;
        later_nz  = (rem_c_q != '0);
        in_run    = 1'b1;
        trk_sel_o = 2'd1;
      end
      S_RUN_C: begin
        cur_rem   = rem_c_q;
        in_run    = 1'b1;
        trk_sel_o = 2'd2;
      end
      default: begin
        cur_rem   = '0;
      end
    endcase
  end

  assign strobe     = in_run & out_ready_i;
  assign more_after = (cur_rem != CNT_BITS'(1)) || later_nz;
  assign busy_o     = (state_q != S_IDLE);

`ifdef TS_SCHED_TRUNC_EN
  localparam int unsigned ISS_BITS = CNT_BITS + 2;

  logic [ISS_BITS-1:0] issued_q, issued_d;
  logic                trunc_q, trunc_d;

  assign cap_hit = in_run && ((issued_q + ISS_BITS'(1)) == ISS_BITS'(MAX_TRK));
  assign trunc_o = trunc_q;

  always_comb begin
    issued_d = issued_q;
    trunc_d  = trunc_q;
    if (state_q == S_LOAD) begin
      issued_d = '0;
      trunc_d  = 1'b0;
    end else if (strobe) begin
      issued_d = issued_q + ISS_BITS'(1);
      // Only flag truncation when the cap actually discarded reads.
      if (cap_hit && more_after) begin
        trunc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q <= '0;
      trunc_q  <= 1'b0;
    end else begin
      issued_q <= issued_d;
      trunc_q  <= trunc_d;
    end
  end
`else
  logic unused_max_trk;

  assign unused_max_trk = ^MAX_TRK;
  assign cap_hit        = 1'b0;
  assign trunc_o        = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    rem_a_d          = rem_a_q;
    rem_b_d          = rem_b_q;
    rem_c_d          = rem_c_q;
    cnt_fifo_rd_en_o = 1'b0;
    trk_rd_en_o      = 3'b000;
    trk_last_o       = 1'b0;
    evt_done_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Pop strobe is gated by reset so it stays low while reset is held.
        if (!cnt_fifo_empty_i) begin
          cnt_fifo_rd_en_o = rst_ni;
          state_d          = S_LOAD;
        end
      end
      S_LOAD: begin
        rem_a_d = ld_a;
        rem_b_d = ld_b;
        rem_c_d = ld_c;
        if (ld_a != '0) begin
          state_d = S_RUN_A;
        end else if (ld_b != '0) begin
          state_d = S_RUN_B;
        end else if (ld_c != '0) begin
          state_d = S_RUN_C;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RUN_A: begin
        if (out_ready_i) begin
          trk_rd_en_o = 3'b001;
          rem_a_d     = rem_a_q - CNT_BITS'(1);
          if (cap_hit) begin
            state_d = S_DONE;
          end else if (rem_a_q == CNT_BITS'(1)) begin
            if (rem_b_q != '0) begin
              state_d = S_RUN_B;
            end else if (rem_c_q != '0) begin
              state_d = S_RUN_C;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_RUN_B: begin
        if (out_ready_i) begin
          trk_rd_en_o = 3'b010;
          rem_b_d     = rem_b_q - CNT_BITS'(1);
          if (cap_hit) begin
            state_d = S_DONE;
          end else if (rem_b_q == CNT_BITS'(1)) begin
            state_d = (rem_c_q != '0) ? S_RUN_C : S_DONE;
          end
        end
      end
      S_RUN_C: begin
        if (out_ready_i) begin
          trk_rd_en_o = 3'b100;
          rem_c_d     = rem_c_q - CNT_BITS'(1);
          if (cap_hit || (rem_c_q == CNT_BITS'(1))) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        evt_done_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    trk_last_o = strobe && (!more_after || cap_hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rem_a_q <= '0;
      rem_b_q <= '0;
      rem_c_q <= '0;
    end else begin
      state_q <= state_d;
      rem_a_q <= rem_a_d;
      rem_b_q <= rem_b_d;
      rem_c_q <= rem_c_d;
    end
  end

endmodule

`default_nettype wire
